// File: rtl/zymason_msg_scroller_if.sv
// Pin-side bundle for the message scroller: write/scan controls in, display pins out.
// The bus has no backpressure. wr_stb qualifies half/data_in for exactly one clock,
// and the scroller always takes it when it is in WRITE with mode still high.
interface zymason_msg_scroller_if #(
  parameter int NUM_DIGITS = 16,
  parameter int SEG_W      = 7,
  parameter int SPD_W      = 5
);
  localparam int PW = $clog2(NUM_DIGITS);

  logic             mode;
  logic             wr_stb;
  logic             half;
  logic [3:0]       data_in;
  logic [SPD_W-1:0] spd;
  logic [SEG_W-1:0] seg_out;
  logic [PW-1:0]    pos_out;
  logic [PW:0]      len_out;
  logic             mode_out;
  logic [1:0]       state_dbg;

  modport master (
    output mode, wr_stb, half, data_in, spd,
    input  seg_out, pos_out, len_out, mode_out, state_dbg
  );

  modport slave (
    input  mode, wr_stb, half, data_in, spd,
    output seg_out, pos_out, len_out, mode_out, state_dbg
  );
endinterface

// File: rtl/zymason_msg_scroller.sv
// Indexed 7-segment message store with a rate-programmable scan over the written digits.
// Optional macro ZYMASON_BLANK_EN inserts one blank display step at each scan wrap.
module zymason_msg_scroller #(
  parameter int NUM_DIGITS = 16,
  parameter int SEG_W      = 7,
  parameter int PRE_W      = 9,
  parameter int SPD_W      = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  zymason_msg_scroller_if.slave  bus
);
  localparam int PW = $clog2(NUM_DIGITS);
  localparam int LW = PW + 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SEG_W-1:0] mem_q [NUM_DIGITS];
  logic [SEG_W-1:0] mem_d [NUM_DIGITS];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    len_q, len_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [SPD_W-1:0] cnt_q, cnt_d;
`ifdef ZYMASON_BLANK_EN
  logic             blank_q, blank_d;
`endif

  logic             tick;
  logic             step;
  logic [LW-1:0]    wp_inc;
  logic [SEG_W-1:0] seg_w;
  logic [PW-1:0]    pos_w;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    len_d   = len_q;
    pre_d   = pre_q + 1'b1;
    cnt_d   = cnt_q;
`ifdef ZYMASON_BLANK_EN
    blank_d = blank_q;
`endif
    tick    = (pre_q == '0);
    step    = 1'b0;
    wp_inc  = {1'b0, wptr_q} + LW'(1);

    case (state_q)
      S_IDLE: state_d = bus.mode ? S_WRITE : S_SCAN;
      S_SCAN: begin
        if (bus.mode) begin
          // Memory is kept; only the write pointer and length restart.
          state_d = S_WRITE;
          wptr_d  = '0;
          len_d   = '0;
`ifdef ZYMASON_BLANK_EN
          blank_d = 1'b0;
`endif
        end else if (tick && (bus.spd != '0) && (len_q != '0)) begin
          // Compare with >= so lowering spd below the count steps on the next tick.
          if (({1'b0, cnt_q} + (SPD_W+1)'(1)) >= {1'b0, bus.spd}) begin
            cnt_d = '0;
            step  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (!bus.mode) begin
          state_d = S_SCAN;
          rptr_d  = '0;
          cnt_d   = '0;
        end else if (bus.wr_stb) begin
          if (!bus.half) begin
            mem_d[wptr_q][3:0] = bus.data_in;
          end else begin
            mem_d[wptr_q][SEG_W-1:4] = bus.data_in[SEG_W-5:0];
            wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
            if (wp_inc > len_q) len_d = wp_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (step) begin
`ifdef ZYMASON_BLANK_EN
      if (blank_q) begin
        blank_d = 1'b0;
        rptr_d  = '0;
      end else if ({1'b0, rptr_q} == (len_q - LW'(1))) begin
        blank_d = 1'b1;
      end else begin
        rptr_d = rptr_q + 1'b1;
      end
`else
      rptr_d = ({1'b0, rptr_q} == (len_q - LW'(1))) ? '0 : rptr_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NUM_DIGITS; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      len_q   <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
`ifdef ZYMASON_BLANK_EN
      blank_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      len_q   <= len_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
`ifdef ZYMASON_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

  // WRITE previews the entry under the write pointer; an empty scan shows nothing.
  always_comb begin
    seg_w = '0;
    pos_w = '0;
    case (state_q)
      S_WRITE: begin
        seg_w = mem_q[wptr_q];
        pos_w = wptr_q;
      end
      S_SCAN: begin
        if (len_q != '0) begin
          seg_w = mem_q[rptr_q];
          pos_w = rptr_q;
`ifdef ZYMASON_BLANK_EN
          if (blank_q) seg_w = '0;
`endif
        end
      end
      default: begin
        seg_w = '0;
        pos_w = '0;
      end
    endcase
  end

  assign bus.seg_out   = seg_w;
  assign bus.pos_out   = pos_w;
  assign bus.len_out   = len_q;
  assign bus.mode_out  = (state_q == S_WRITE);
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_zymason_msg_scroller.sv
// Directed bench for zymason_msg_scroller with a 4-clock base tick (PRE_W = 2).
// All drives and samples happen 1 time unit after the rising clock edge.
module tb_zymason_msg_scroller;
  localparam int NUM_DIGITS = 16;
  localparam int SEG_W      = 7;
  localparam int PRE_W      = 2;
  localparam int SPD_W      = 5;

  logic clock;
  logic reset;

  zymason_msg_scroller_if #(
    .NUM_DIGITS (NUM_DIGITS),
    .SEG_W      (SEG_W),
    .SPD_W      (SPD_W)
  ) bus ();

  zymason_msg_scroller #(
    .NUM_DIGITS (NUM_DIGITS),
    .SEG_W      (SEG_W),
    .PRE_W      (PRE_W),
    .SPD_W      (SPD_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       stb;
    logic       half;
    logic [3:0] data;
    logic [6:0] seg;
    logic [3:0] pos;
    logic [4:0] len;
  } vec_t;

  vec_t       vecs [6];
  logic [6:0] exp_q [$];
  logic [6:0] last_exp;
  int         n_checks;
  int         n_errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [6:0] seg, input logic [3:0] pos,
                            input logic [4:0] len, input logic modeo);
    check({name, ".seg"},  32'(bus.seg_out),  32'(seg));
    check({name, ".pos"},  32'(bus.pos_out),  32'(pos));
    check({name, ".len"},  32'(bus.len_out),  32'(len));
    check({name, ".mode"}, 32'(bus.mode_out), 32'(modeo));
  endtask

  // driver tasks: each starts and ends 1 unit after a rising edge
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic write_nib(input logic h, input logic [3:0] d);
    bus.wr_stb  = 1'b1;
    bus.half    = h;
    bus.data_in = d;
    cycles(1);
    bus.wr_stb  = 1'b0;
  endtask

  task automatic write_digit(input logic [6:0] v);
    write_nib(1'b0, v[3:0]);
    write_nib(1'b1, {1'b0, v[6:4]});
  endtask

  // scoreboard: every seg_out change must match the queue head and come `period` clocks apart
  task automatic watch(input int period, input int budget);
    int         cyc;
    int         last;
    int         bad_pos;
    logic [6:0] prev;
    cyc     = 0;
    last    = -1;
    bad_pos = 0;
    prev    = bus.seg_out;
    while (exp_q.size() > 0 && cyc < budget) begin
      cycles(1);
      cyc++;
      if ({1'b0, bus.pos_out} >= bus.len_out) bad_pos++;
      if (bus.seg_out !== prev) begin
        last_exp = exp_q.pop_front();
        check("scan_val", 32'(bus.seg_out), 32'(last_exp));
        if (last >= 0) check("scan_period", 32'(cyc - last), 32'(period));
        last = cyc;
        prev = bus.seg_out;
      end
    end
    check("scan_remaining", 32'(exp_q.size()), 32'd0);
    check("scan_pos_range", 32'(bad_pos), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int bad;
    n_checks = 0;
    n_errors = 0;
    last_exp = '0;

    //            stb   half  data   seg    pos   len
    vecs[0] = '{1'b1, 1'b0, 4'h6, 7'h06, 4'd0, 5'd0};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 7'h00, 4'd1, 5'd1};
    vecs[2] = '{1'b0, 1'b1, 4'hf, 7'h00, 4'd1, 5'd1};
    vecs[3] = '{1'b1, 1'b0, 4'h1, 7'h01, 4'd1, 5'd1};
    vecs[4] = '{1'b1, 1'b1, 4'h1, 7'h00, 4'd2, 5'd2};
    vecs[5] = '{1'b0, 1'b0, 4'h9, 7'h00, 4'd2, 5'd2};

    reset       = 1'b1;
    bus.mode    = 1'b1;
    bus.wr_stb  = 1'b0;
    bus.half    = 1'b0;
    bus.data_in = 4'h0;
    bus.spd     = '0;
    @(posedge clock);
    #1;
    check_outs("in_reset", 7'h00, 4'd0, 5'd0, 1'b0);
    cycles(1);
    reset = 1'b0;
    cycles(1);
    check_outs("after_reset", 7'h00, 4'd0, 5'd0, 1'b1);

    // table: nibble writes with live preview
    for (int i = 0; i < 6; i++) begin
      bus.wr_stb  = vecs[i].stb;
      bus.half    = vecs[i].half;
      bus.data_in = vecs[i].data;
      cycles(1);
      bus.wr_stb  = 1'b0;
      check_outs($sformatf("vec%0d", i), vecs[i].seg, vecs[i].pos, vecs[i].len, 1'b1);
    end

    // enter scan: entry 0 must hold 0x36
    bus.mode = 1'b0;
    bus.spd  = 5'd1;
    cycles(1);
    check_outs("scan_entry", 7'h36, 4'd0, 5'd2, 1'b0);

    // strobe on the SCAN->WRITE transition cycle is ignored
    bus.mode    = 1'b1;
    bus.wr_stb  = 1'b1;
    bus.half    = 1'b1;
    bus.data_in = 4'h7;
    cycles(1);
    bus.wr_stb  = 1'b0;
    check_outs("trans_strobe", 7'h36, 4'd0, 5'd0, 1'b1);

    write_digit(7'h11);
    write_digit(7'h22);
    write_digit(7'h33);
    check_outs("three_written", 7'h00, 4'd3, 5'd3, 1'b1);

    // scan spd = 1: one step per base tick
    bus.mode = 1'b0;
    bus.spd  = 5'd1;
    cycles(1);
    check_outs("scan3_start", 7'h11, 4'd0, 5'd3, 1'b0);
`ifdef ZYMASON_BLANK_EN
    exp_q = '{7'h22, 7'h33, 7'h00, 7'h11, 7'h22};
`else
    exp_q = '{7'h22, 7'h33, 7'h11, 7'h22};
`endif
    watch(4, 40);

    // spd = 3: step every 12 clocks
    bus.spd = 5'd3;
`ifdef ZYMASON_BLANK_EN
    exp_q = '{7'h33, 7'h00, 7'h11};
`else
    exp_q = '{7'h33, 7'h11, 7'h22};
`endif
    watch(12, 60);

    // spd = 0 freezes the display
    bus.spd = 5'd0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (bus.seg_out !== last_exp) bad++;
    end
    check("freeze", 32'(bad), 32'd0);

    // overflow: 17 writes wrap onto entry 0, len saturates
    bus.mode = 1'b1;
    cycles(1);
    check_outs("rewrite_entry", 7'h11, 4'd0, 5'd0, 1'b1);
    for (int k = 0; k < 16; k++) write_digit(7'h40 + 7'(k));
    check_outs("full16", 7'h40, 4'd0, 5'd16, 1'b1);
    write_digit(7'h50);
    check_outs("full17", 7'h41, 4'd1, 5'd16, 1'b1);
    bus.mode = 1'b0;
    cycles(1);
    check_outs("full_scan0", 7'h50, 4'd0, 5'd16, 1'b0);

    // scan with nothing written stays dark
    bus.mode = 1'b1;
    cycles(1);
    bus.mode = 1'b0;
    bus.spd  = 5'd1;
    cycles(1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (bus.seg_out !== 7'h00 || bus.pos_out !== 4'd0) bad++;
    end
    check("empty_scan", 32'(bad), 32'd0);
    check("empty_len", 32'(bus.len_out), 32'd0);

    // asynchronous reset in the middle of a scan
    bus.mode = 1'b1;
    cycles(1);
    write_digit(7'h11);
    write_digit(7'h22);
    bus.mode = 1'b0;
    cycles(7);
    check("pre_reset_len", 32'(bus.len_out), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check_outs("async_reset", 7'h00, 4'd0, 5'd0, 1'b0);
    cycles(2);
    reset = 1'b0;
    cycles(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
